ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single-port byte-addressed data RAM between the instruction-fetch requester (IF, read-only) and the load/store requester (LS, read/write).
- Provides per-requester valid/ready request handshakes with round-robin arbitration on conflict.
- Generates RAM byte enables from the access size and sign/zero-extends load data.
- Returns a registered response one cycle after acceptance and rejects out-of-range accesses with an error response.

Parameters:
- SIZE, 1024, RAM depth in bytes; must match the attached RAM instance.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req_valid_i  in  1  IF read request valid
- if_req_ready_o  out  1  IF request accepted this cycle
- if_addr_i  in  XLEN  IF byte address
- if_rsp_valid_o  out  1  IF response valid (single-cycle pulse)
- if_rsp_data_o  out  XLEN  IF read data, raw 8 bytes from addr
- if_rsp_err_o  out  1  IF access out of range
- ls_req_valid_i  in  1  LS request valid
- ls_req_ready_o  out  1  LS request accepted this cycle
- ls_addr_i  in  XLEN  LS byte address
- ls_wen_i  in  1  1 = store, 0 = load
- ls_size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = double
- ls_unsigned_i  in  1  load zero-extend (1) / sign-extend (0)
- ls_wdata_i  in  XLEN  store data, LSB-aligned
- ls_rsp_valid_o  out  1  LS response valid (pulse; store ack or load data)
- ls_rsp_data_o  out  XLEN  extended load data; 0 for stores and errors
- ls_rsp_err_o  out  1  LS access out of range
- ram_addr_o  out  XLEN  RAM address
- ram_wen_o  out  1  RAM write enable
- ram_byte_en_o  out  8  RAM byte enables
- ram_wdata_o  out  XLEN  RAM write data
- ram_ren_o  out  1  RAM read enable
- ram_rdata_i  in  XLEN  RAM combinational read data

Behaviour:
- Reset (synchronous, active-high): all rsp_valid/err/data outputs 0, prio register = LS, any pending response dropped. During a reset cycle both ready outputs are 0 and ram_wen_o/ram_ren_o are 0.
- Arbitration:
  - Only one requester valid: it is granted.
  - Both valid: the prio holder is granted and prio flips to the other requester.
  - Only-one-valid grants leave prio unchanged.
- ready_o is combinational: ready = grant & !rst. A request is accepted when valid & ready. Requesters hold valid and payload until accepted. There is no response backpressure; a requester must always accept its response.
- Accept-cycle RAM drive (combinational, same cycle):
  - ram_addr_o = winner address.
  - ram_ren_o = accept & !store.
  - ram_wen_o = accept & store & in_range.
  - ram_wdata_o = ls_wdata_i.
- Byte enables: IF = 0xFF. LS size 0/1/2/3 gives 0x01/0x03/0x0F/0xFF. Byte enables are driven to 0 when there is no accept.
- Range check: an access is in range iff addr + 8 <= SIZE. The check always covers a full 8 bytes because the RAM reads 8 bytes for a read-modify-write. It uses the full XLEN address with no wrap.
  - Out of range: no RAM enable is asserted. The response is issued with err = 1 and data = 0.
- Response timing:
  - At the accept posedge, the controller captures ram_rdata_i, the LS size/unsigned flags and the error flag into the owning port's response register.
  - rsp_valid is high for exactly the next cycle, then returns to 0 unless a new accept occurred.
  - Latency is 1 cycle. Throughput is 1 accept per cycle in total.
- Load extension (size, unsigned): byte/half/word take bits [7:0]/[15:0]/[31:0] and sign- or zero-extend to XLEN; double passes through. IF data is never extended.
- Store followed by load of the same address on the next cycle returns the newly written bytes, since the RAM array updates at the accept edge.
- Simultaneous IF and LS requests to the same address: the arbitration order above applies, with no bypassing.
- Reset asserted while a response is pending: the response is suppressed and rsp_valid stays 0.

Decomposition:
- Shared defines header holds XLEN and the size encodings: SIZE_B = 0, SIZE_H = 1, SIZE_W = 2, SIZE_D = 3.
- Sub-module load_ext: combinational (size, unsigned, raw data) -> extended data. The byte-enable decode stays inline.

Test Plan:
- Reset, then LS load size 3 at addr 0x10 with RAM bytes 0x01..0x08 -> ls_rsp_valid_o the next cycle, data 0x0807060504030201, err = 0.
- LS store size 1, data 0xAAAA_BEEF at addr 0x20, then LS load size 1 unsigned = 0 at 0x20 -> ram_byte_en_o = 0x03 on the store; load returns 0xFFFF_FFFF_FFFF_BEEF; bytes 0x22..0x27 unchanged.
- IF and LS both valid for 4 consecutive cycles after reset -> grants in order LS, IF, LS, IF; each response arrives exactly 1 cycle after its accept.
- LS store at addr SIZE-4 = 1020 -> ram_wen_o stays 0, ls_rsp_err_o = 1, data 0. Same test at addr 1016 -> success.
- LS load size 0 unsigned = 1 of byte 0x80 -> 0x80. With unsigned = 0 -> 0xFFFF_FFFF_FFFF_FF80.
- IF request accepted, rst asserted the next cycle -> if_rsp_valid_o = 0, both ready outputs 0 during reset, prio returns to LS.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared widths, access-size encodings and byte-enable decode for the data RAM arbiter.
package ram_arbiter_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned BE_W = XLEN / 8;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    typedef enum logic {
        PRIO_LS = 1'b0,
        PRIO_IF = 1'b1
    } prio_e;

    // LSB-aligned byte lanes touched by an access of the given size.
    function automatic logic [BE_W-1:0] size_to_be(input logic [1:0] size);
        case (size)
            SIZE_B:  return BE_W'(8'h01);
            SIZE_H:  return BE_W'(8'h03);
            SIZE_W:  return BE_W'(8'h0F);
            default: return BE_W'(8'hFF);
        endcase
    endfunction

endpackage

// File: rtl/ram_arbiter_load_ext.sv
// Selects the low byte/half/word of raw load data and sign- or zero-extends it.
module ram_arbiter_load_ext
    import ram_arbiter_pkg::*;
(
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    input  logic [XLEN-1:0] raw,
    output logic [XLEN-1:0] data
);

    always_comb begin
        data = raw;
        case (size)
            SIZE_B: data = is_unsigned ? XLEN'(raw[7:0])
                                       : {{(XLEN-8){raw[7]}}, raw[7:0]};
            SIZE_H: data = is_unsigned ? XLEN'(raw[15:0])
                                       : {{(XLEN-16){raw[15]}}, raw[15:0]};
            SIZE_W: data = is_unsigned ? XLEN'(raw[31:0])
                                       : {{(XLEN-32){raw[31]}}, raw[31:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one byte-addressed data RAM between instruction fetch
// and load/store, with range checking and a one-cycle registered response.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned SIZE = 1024
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            if_req_valid_i,
    output logic            if_req_ready_o,
    input  logic [XLEN-1:0] if_addr_i,
    output logic            if_rsp_valid_o,
    output logic [XLEN-1:0] if_rsp_data_o,
    output logic            if_rsp_err_o,

    input  logic            ls_req_valid_i,
    output logic            ls_req_ready_o,
    input  logic [XLEN-1:0] ls_addr_i,
    input  logic            ls_wen_i,
    input  logic [1:0]      ls_size_i,
    input  logic            ls_unsigned_i,
    input  logic [XLEN-1:0] ls_wdata_i,
    output logic            ls_rsp_valid_o,
    output logic [XLEN-1:0] ls_rsp_data_o,
    output logic            ls_rsp_err_o,

    output logic [XLEN-1:0] ram_addr_o,
    output logic            ram_wen_o,
    output logic [BE_W-1:0] ram_byte_en_o,
    output logic [XLEN-1:0] ram_wdata_o,
    output logic            ram_ren_o,
    input  logic [XLEN-1:0] ram_rdata_i
);

    // One extra bit so addr + 8 cannot wrap past the top of the address space.
    localparam int unsigned    AW    = XLEN + 1;
    localparam logic [AW-1:0]  LIMIT = AW'(SIZE);

    prio_e           prio_q;
    prio_e           prio_d;
    logic            grant_if;
    logic            grant_ls;
    logic            accept_if;
    logic            accept_ls;
    logic [XLEN-1:0] req_addr;
    logic            in_range;

    logic            if_rsp_valid_q;
    logic            if_rsp_err_q;
    logic [XLEN-1:0] if_rsp_data_q;
    logic            ls_rsp_valid_q;
    logic            ls_rsp_err_q;
    logic [XLEN-1:0] ls_rsp_raw_q;
    logic [1:0]      ls_rsp_size_q;
    logic            ls_rsp_unsigned_q;
    logic [XLEN-1:0] ls_ext_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= PRIO_LS;
        end else begin
            prio_q <= prio_d;
        end
    end

    // Conflicts go to the priority holder and hand priority over; lone requests leave it alone.
    always_comb begin
        prio_d   = prio_q;
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (if_req_valid_i && ls_req_valid_i) begin
            if (prio_q == PRIO_IF) begin
                grant_if = 1'b1;
                prio_d   = PRIO_LS;
            end else begin
                grant_ls = 1'b1;
                prio_d   = PRIO_IF;
            end
        end else if (if_req_valid_i) begin
            grant_if = 1'b1;
        end else if (ls_req_valid_i) begin
            grant_ls = 1'b1;
        end
    end

    assign if_req_ready_o = grant_if & ~rst;
    assign ls_req_ready_o = grant_ls & ~rst;
    assign accept_if      = if_req_valid_i & if_req_ready_o;
    assign accept_ls      = ls_req_valid_i & ls_req_ready_o;

    assign req_addr = accept_if ? if_addr_i : ls_addr_i;
    assign in_range = ({1'b0, req_addr} + AW'(8)) <= LIMIT;

    assign ram_addr_o  = req_addr;
    assign ram_wdata_o = ls_wdata_i;
    assign ram_ren_o   = (accept_if | (accept_ls & ~ls_wen_i)) & in_range;
    assign ram_wen_o   = accept_ls & ls_wen_i & in_range;

    always_comb begin
        ram_byte_en_o = '0;
        if (accept_if) begin
            ram_byte_en_o = '1;
        end else if (accept_ls) begin
            ram_byte_en_o = size_to_be(ls_size_i);
        end
    end

    // Response registers; stores and rejected accesses capture zero data.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rsp_valid_q    <= 1'b0;
            if_rsp_err_q      <= 1'b0;
            if_rsp_data_q     <= '0;
            ls_rsp_valid_q    <= 1'b0;
            ls_rsp_err_q      <= 1'b0;
            ls_rsp_raw_q      <= '0;
            ls_rsp_size_q     <= SIZE_D;
            ls_rsp_unsigned_q <= 1'b0;
        end else begin
            if_rsp_valid_q <= accept_if;
            ls_rsp_valid_q <= accept_ls;
            if (accept_if) begin
                if_rsp_err_q  <= ~in_range;
                if_rsp_data_q <= in_range ? ram_rdata_i : '0;
            end
            if (accept_ls) begin
                ls_rsp_err_q      <= ~in_range;
                ls_rsp_raw_q      <= (in_range && !ls_wen_i) ? ram_rdata_i : '0;
                ls_rsp_size_q     <= ls_size_i;
                ls_rsp_unsigned_q <= ls_unsigned_i;
            end
        end
    end

    ram_arbiter_load_ext u_load_ext (
        .size        (ls_rsp_size_q),
        .is_unsigned (ls_rsp_unsigned_q),
        .raw         (ls_rsp_raw_q),
        .data        (ls_ext_data)
    );

    // A response still pending when reset arrives is masked for that cycle, then cleared.
    assign if_rsp_valid_o = if_rsp_valid_q & ~rst;
    assign if_rsp_err_o   = if_rsp_err_q & ~rst;
    assign if_rsp_data_o  = if_rsp_data_q & {XLEN{~rst}};
    assign ls_rsp_valid_o = ls_rsp_valid_q & ~rst;
    assign ls_rsp_err_o   = ls_rsp_err_q & ~rst;
    assign ls_rsp_data_o  = ls_ext_data & {XLEN{~rst}};

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed requests push expected responses,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int unsigned SIZE = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid, if_ready, if_rsp_valid, if_rsp_err;
    logic [63:0] if_addr, if_rsp_data;
    logic        ls_valid, ls_ready, ls_wen, ls_uns, ls_rsp_valid, ls_rsp_err;
    logic [1:0]  ls_size;
    logic [63:0] ls_addr, ls_wdata, ls_rsp_data;
    logic [63:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_wen, ram_ren;
    logic [7:0]  ram_byte_en;

    always #5 clk = ~clk;

    ram_arbiter #(.SIZE(SIZE)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid_i(if_valid), .if_req_ready_o(if_ready), .if_addr_i(if_addr),
        .if_rsp_valid_o(if_rsp_valid), .if_rsp_data_o(if_rsp_data), .if_rsp_err_o(if_rsp_err),
        .ls_req_valid_i(ls_valid), .ls_req_ready_o(ls_ready), .ls_addr_i(ls_addr),
        .ls_wen_i(ls_wen), .ls_size_i(ls_size), .ls_unsigned_i(ls_uns), .ls_wdata_i(ls_wdata),
        .ls_rsp_valid_o(ls_rsp_valid), .ls_rsp_data_o(ls_rsp_data), .ls_rsp_err_o(ls_rsp_err),
        .ram_addr_o(ram_addr), .ram_wen_o(ram_wen), .ram_byte_en_o(ram_byte_en),
        .ram_wdata_o(ram_wdata), .ram_ren_o(ram_ren), .ram_rdata_i(ram_rdata)
    );

    // Byte-addressed RAM: combinational 8-byte read, byte-enabled write at the clock edge.
    logic [7:0] mem [0:SIZE-1];

    always_comb begin
        ram_rdata = '0;
        for (int i = 0; i < 8; i++) begin
            if (ram_addr < 64'(SIZE - i)) ram_rdata[i*8 +: 8] = mem[int'(ram_addr[9:0]) + i];
        end
    end

    always @(posedge clk) begin
        if (ram_wen) begin
            for (int i = 0; i < 8; i++) begin
                if (ram_byte_en[i]) mem[int'(ram_addr[9:0]) + i] <= ram_wdata[i*8 +: 8];
            end
        end
    end

    typedef struct packed {
        int unsigned cyc;
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t        if_q[$];
    exp_t        ls_q[$];
    int unsigned cycle = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic push_if(input logic [63:0] data, input logic err);
        exp_t e;
        e = '{cyc: cycle + 1, data: data, err: err};
        if_q.push_back(e);
    endtask

    task automatic push_ls(input logic [63:0] data, input logic err);
        exp_t e;
        e = '{cyc: cycle + 1, data: data, err: err};
        ls_q.push_back(e);
    endtask

    // Monitor: every response pulse must match the oldest expectation for its port, in the right cycle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (if_rsp_valid) begin
                if (if_q.size() == 0) begin
                    check("if_unexpected_rsp", 64'(if_rsp_valid), 64'd0);
                end else begin
                    e = if_q.pop_front();
                    check("if_rsp_data", if_rsp_data, e.data);
                    check("if_rsp_err", 64'(if_rsp_err), 64'(e.err));
                    check("if_rsp_cycle", 64'(cycle), 64'(e.cyc));
                end
            end
            if (ls_rsp_valid) begin
                if (ls_q.size() == 0) begin
                    check("ls_unexpected_rsp", 64'(ls_rsp_valid), 64'd0);
                end else begin
                    e = ls_q.pop_front();
                    check("ls_rsp_data", ls_rsp_data, e.data);
                    check("ls_rsp_err", 64'(ls_rsp_err), 64'(e.err));
                    check("ls_rsp_cycle", 64'(cycle), 64'(e.cyc));
                end
            end
        end
    end

    // Issue one LS request (called just after a posedge); reports the RAM drive seen at accept.
    task automatic ls_req(input logic [63:0] addr, input logic wen, input logic [1:0] size,
                          input logic uns, input logic [63:0] wdata,
                          input logic [63:0] exp_data, input logic exp_err,
                          output logic a_wen, output logic a_ren, output logic [7:0] a_be);
        bit done = 1'b0;
        a_wen = 1'b0; a_ren = 1'b0; a_be = '0;
        ls_valid = 1'b1; ls_addr = addr; ls_wen = wen; ls_size = size;
        ls_uns = uns; ls_wdata = wdata;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (ls_ready) begin
                done  = 1'b1;
                a_wen = ram_wen; a_ren = ram_ren; a_be = ram_byte_en;
                push_ls(exp_data, exp_err);
            end
            @(posedge clk); #1;
        end
        ls_valid = 1'b0;
        if (!done) check("ls_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic if_req(input logic [63:0] addr, input logic [63:0] exp_data, input logic exp_err,
                          output logic a_ren, output logic [7:0] a_be);
        bit done = 1'b0;
        a_ren = 1'b0; a_be = '0;
        if_valid = 1'b1; if_addr = addr;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (if_ready) begin
                done  = 1'b1;
                a_ren = ram_ren; a_be = ram_byte_en;
                push_if(exp_data, exp_err);
            end
            @(posedge clk); #1;
        end
        if_valid = 1'b0;
        if (!done) check("if_accept_timeout", 64'd0, 64'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    logic       a_wen, a_ren;
    logic [7:0] a_be;
    logic       exp_ls_first [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        rst = 1'b1;
        if_valid = 1'b1; if_addr = 64'h100;
        ls_valid = 1'b1; ls_addr = 64'h100; ls_wen = 1'b1; ls_size = SIZE_D;
        ls_uns = 1'b0; ls_wdata = 64'hDEAD_BEEF;

        // Reset: no grants and no RAM enables even with both requesters valid.
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_if_ready", 64'(if_ready), 64'd0);
        check("rst_ls_ready", 64'(ls_ready), 64'd0);
        check("rst_ram_wen", 64'(ram_wen), 64'd0);
        check("rst_ram_ren", 64'(ram_ren), 64'd0);
        check("rst_ram_be", 64'(ram_byte_en), 64'd0);
        check("rst_if_rsp_valid", 64'(if_rsp_valid), 64'd0);
        check("rst_ls_rsp_valid", 64'(ls_rsp_valid), 64'd0);
        check("rst_ls_rsp_data", ls_rsp_data, 64'd0);
        check("rst_ls_rsp_err", 64'(ls_rsp_err), 64'd0);
        @(posedge clk); #1;
        if_valid = 1'b0; ls_valid = 1'b0; ls_wen = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("idle_if_rsp_valid", 64'(if_rsp_valid), 64'd0);
        @(posedge clk); #1;

        // Preload RAM through the LS store path.
        ls_req(64'h10, 1'b1, SIZE_D, 1'b0, 64'h0807_0605_0403_0201, 64'd0, 1'b0, a_wen, a_ren, a_be);
        check("pre0_wen", 64'(a_wen), 64'd1);
        check("pre0_be", 64'(a_be), 64'hFF);
        ls_req(64'h20, 1'b1, SIZE_D, 1'b0, 64'h3736_3534_3332_3130, 64'd0, 1'b0, a_wen, a_ren, a_be);
        ls_req(64'h40, 1'b1, SIZE_D, 1'b0, 64'h8000_0000_0000_0080, 64'd0, 1'b0, a_wen, a_ren, a_be);

        // Double load of 0x01..0x08.
        ls_req(64'h10, 1'b0, SIZE_D, 1'b0, 64'd0, 64'h0807_0605_0403_0201, 1'b0, a_wen, a_ren, a_be);
        check("ld_d_ren", 64'(a_ren), 64'd1);
        check("ld_d_wen", 64'(a_wen), 64'd0);

        // Half store then signed half load; upper bytes of the doubleword untouched.
        ls_req(64'h20, 1'b1, SIZE_H, 1'b0, 64'hAAAA_BEEF, 64'd0, 1'b0, a_wen, a_ren, a_be);
        check("st_h_be", 64'(a_be), 64'h03);
        check("st_h_wen", 64'(a_wen), 64'd1);
        check("st_h_ren", 64'(a_ren), 64'd0);
        ls_req(64'h20, 1'b0, SIZE_H, 1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_BEEF, 1'b0, a_wen, a_ren, a_be);
        ls_req(64'h20, 1'b0, SIZE_D, 1'b0, 64'd0, 64'h3736_3534_3332_BEEF, 1'b0, a_wen, a_ren, a_be);

        // Extension cases.
        ls_req(64'h40, 1'b0, SIZE_B, 1'b1, 64'd0, 64'h80, 1'b0, a_wen, a_ren, a_be);
        check("ld_b_be", 64'(a_be), 64'h01);
        ls_req(64'h40, 1'b0, SIZE_B, 1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, a_wen, a_ren, a_be);
        ls_req(64'h40, 1'b0, SIZE_H, 1'b0, 64'd0, 64'h0080, 1'b0, a_wen, a_ren, a_be);
        ls_req(64'h44, 1'b0, SIZE_W, 1'b0, 64'd0, 64'hFFFF_FFFF_8000_0000, 1'b0, a_wen, a_ren, a_be);
        check("ld_w_be", 64'(a_be), 64'h0F);
        ls_req(64'h44, 1'b0, SIZE_W, 1'b1, 64'd0, 64'h0000_0000_8000_0000, 1'b0, a_wen, a_ren, a_be);

        // Range boundary: 1016 is the last legal 8-byte window.
        ls_req(64'd1020, 1'b1, SIZE_W, 1'b0, 64'h5555_5555, 64'd0, 1'b1, a_wen, a_ren, a_be);
        check("oor_st_wen", 64'(a_wen), 64'd0);
        ls_req(64'd1016, 1'b1, SIZE_D, 1'b0, 64'h1122_3344_5566_7788, 64'd0, 1'b0, a_wen, a_ren, a_be);
        check("edge_st_wen", 64'(a_wen), 64'd1);
        ls_req(64'd1016, 1'b0, SIZE_D, 1'b0, 64'd0, 64'h1122_3344_5566_7788, 1'b0, a_wen, a_ren, a_be);
        ls_req(64'd1017, 1'b0, SIZE_B, 1'b1, 64'd0, 64'd0, 1'b1, a_wen, a_ren, a_be);
        check("oor_ld_ren", 64'(a_ren), 64'd0);
        if_req(64'd1016, 64'h1122_3344_5566_7788, 1'b0, a_ren, a_be);
        check("if_be", 64'(a_be), 64'hFF);
        check("if_ren", 64'(a_ren), 64'd1);
        if_req(64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1'b1, a_ren, a_be);
        check("if_wrap_ren", 64'(a_ren), 64'd0);

        // Let the last response drain, then reset so priority starts at LS.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Both valid for four cycles: LS, IF, LS, IF.
        if_valid = 1'b1; if_addr = 64'h10;
        ls_valid = 1'b1; ls_addr = 64'h40; ls_wen = 1'b0; ls_size = SIZE_B; ls_uns = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("arb_ls_ready", 64'(ls_ready), 64'(exp_ls_first[k]));
            check("arb_if_ready", 64'(if_ready), 64'(!exp_ls_first[k]));
            if (ls_ready) push_ls(64'h80, 1'b0);
            if (if_ready) push_if(64'h0807_0605_0403_0201, 1'b0);
            @(posedge clk); #1;
        end
        if_valid = 1'b0; ls_valid = 1'b0;
        @(posedge clk); #1;

        // Hand priority to IF, accept an IF fetch, then reset before its response appears.
        if_valid = 1'b1; ls_valid = 1'b1;
        @(negedge clk);
        check("pend_ls_grant", 64'(ls_ready), 64'd1);
        if (ls_ready) push_ls(64'h80, 1'b0);
        @(posedge clk); #1;
        ls_valid = 1'b0;
        @(negedge clk);
        check("pend_if_grant", 64'(if_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1; ls_valid = 1'b1;
        @(negedge clk);
        check("pend_if_rsp_valid", 64'(if_rsp_valid), 64'd0);
        check("pend_rst_if_ready", 64'(if_ready), 64'd0);
        check("pend_rst_ls_ready", 64'(ls_ready), 64'd0);
        check("pend_rst_ren", 64'(ram_ren), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_prio_ls", 64'(ls_ready), 64'd1);
        check("post_rst_if_rsp_valid", 64'(if_rsp_valid), 64'd0);
        if (ls_ready) push_ls(64'h80, 1'b0);
        @(posedge clk); #1;
        ls_valid = 1'b0;
        @(negedge clk);
        check("post_rst_if_grant", 64'(if_ready), 64'd1);
        if (if_ready) push_if(64'h0807_0605_0403_0201, 1'b0);
        @(posedge clk); #1;
        if_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("if_q_drained", 64'(if_q.size()), 64'd0);
        check("ls_q_drained", 64'(ls_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
